// File: rtl/cpu_pkg.sv
// Shared constants and encodings for the multicycle CPU datapath.
// The fetch FSM states and next-PC select codes live here so control and datapath agree.
package cpu_pkg;

  localparam int PC_WIDTH   = 16;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    REQ    = 2'b01,
    HOLD   = 2'b10,
    HALTED = 2'b11
  } fetchState_e;

  typedef enum logic [1:0] {
    PCSRC_ALU  = 2'b00,
    PCSRC_JUMP = 2'b01,
    PCSRC_INC  = 2'b10,
    PCSRC_HOLD = 2'b11
  } pcSrc_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selector: ALU result, jump field, PC+1 or hold.
// Pure mux with no state; the fetch unit decides when the selection is committed.
module pc_next_sel #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int PC_WIDTH   = cpu_pkg::PC_WIDTH
) (
  input  logic [1:0]            pcSrc,
  input  logic [DATA_WIDTH-1:0] aluResult,
  input  logic [PC_WIDTH-1:0]   jumpTarget,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic [PC_WIDTH-1:0]   nextPc
);
  import cpu_pkg::*;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    nextPc = pc;
    case (pcSrc)
      PCSRC_ALU:  nextPc = aluResult[PC_WIDTH-1:0];
      PCSRC_JUMP: nextPc = jumpTarget;
      PCSRC_INC:  nextPc = pc + PC_WIDTH'(1);
      PCSRC_HOLD: nextPc = pc;
      default:    nextPc = pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction register for the multicycle datapath.
// Fetches over a req/ack port, holds the IR until control releases it, and applies PC redirects.
module pc_fetch_unit #(
  parameter int                    DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int                    PC_WIDTH   = cpu_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] ir_out,
  output logic                  ir_valid,
  input  logic                  fetch_next,
  input  logic                  halt,
  input  logic                  pc_write,
  input  logic                  pc_write_cond,
  input  logic                  alu_zero,
  input  logic [1:0]            pc_src,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [PC_WIDTH-1:0]   jump_target,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic                  halted
);
  import cpu_pkg::*;

  fetchState_e           state;
  logic [PC_WIDTH-1:0]   pcReg;
  logic [PC_WIDTH-1:0]   nextPc;
  logic [DATA_WIDTH-1:0] irReg;
  logic                  irValid;
  logic                  redirect;

  pc_next_sel #(
    .DATA_WIDTH(DATA_WIDTH),
    .PC_WIDTH  (PC_WIDTH)
  ) u_pc_next_sel (
    .pcSrc     (pc_src),
    .aluResult (alu_result),
    .jumpTarget(jump_target),
    .pc        (pcReg),
    .nextPc    (nextPc)
  );

  assign redirect = pc_write | (pc_write_cond & alu_zero);

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the IR is a single register, not a memory, so clearing it on reset is cheap and keeps ir_out defined.
      state   <= IDLE;
      pcReg   <= RESET_PC;
      irReg   <= '0;
      irValid <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ack) begin
            irReg   <= imem_rdata;
            pcReg   <= pcReg + PC_WIDTH'(1);
            irValid <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          // A redirect coinciding with fetch_next steers the very next fetch.
          if (redirect) pcReg <= nextPc;
          if (fetch_next) begin
            irValid <= 1'b0;
            state   <= halt ? HALTED : REQ;
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_req  = (state == REQ);
  assign halted    = (state == HALTED);
  assign imem_addr = pcReg;
  assign pc_out    = pcReg;
  assign ir_out    = irReg;
  assign ir_valid  = irValid;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios then randomized traffic against a behavioural model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic        fetchNext, halt, pcWrite, pcWriteCond, aluZero;
  logic [1:0]  pcSrc;
  logic [31:0] aluResult;
  logic [15:0] jumpTarget;

  logic        imemReq, irValid, haltedOut;
  logic [15:0] imemAddr, pcOut;
  logic [31:0] irOut;

  logic        wrapReq, wrapValid, wrapHalted;
  logic [15:0] wrapAddr, wrapPc;
  logic [31:0] wrapIr;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the fetch unit, expressed as a few flags.
  logic [15:0] mPc;
  logic [31:0] mIr;
  logic        mValid, mStarted, mFetching, mStopped;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imemReq), .imem_addr(imemAddr), .imem_ack(imemAck), .imem_rdata(imemRdata),
    .ir_out(irOut), .ir_valid(irValid),
    .fetch_next(fetchNext), .halt(halt),
    .pc_write(pcWrite), .pc_write_cond(pcWriteCond), .alu_zero(aluZero),
    .pc_src(pcSrc), .alu_result(aluResult), .jump_target(jumpTarget),
    .pc_out(pcOut), .halted(haltedOut)
  );

  pc_fetch_unit #(.RESET_PC(16'hFFFF)) dutWrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(wrapReq), .imem_addr(wrapAddr), .imem_ack(imemAck), .imem_rdata(imemRdata),
    .ir_out(wrapIr), .ir_valid(wrapValid),
    .fetch_next(fetchNext), .halt(halt),
    .pc_write(pcWrite), .pc_write_cond(pcWriteCond), .alu_zero(aluZero),
    .pc_src(pcSrc), .alu_result(aluResult), .jump_target(jumpTarget),
    .pc_out(wrapPc), .halted(wrapHalted)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, got, want);
    end
  endtask

  task automatic idleInputs();
    imemAck = 0; imemRdata = '0; fetchNext = 0; halt = 0;
    pcWrite = 0; pcWriteCond = 0; aluZero = 0; pcSrc = 2'b11;
    aluResult = '0; jumpTarget = '0;
  endtask

  task automatic modelReset();
    mPc = 16'h0000; mIr = '0; mValid = 0;
    mStarted = 0; mFetching = 0; mStopped = 0;
  endtask

  function automatic logic [15:0] selectPc(input logic [1:0] src, input logic [31:0] alu,
                                           input logic [15:0] jt, input logic [15:0] pc);
    case (src)
      2'd0:    return alu[15:0];
      2'd1:    return jt;
      2'd2:    return 16'((32'(pc) + 1) % 65536);
      default: return pc;
    endcase
  endfunction

  // One rising edge of the specified behaviour, using the inputs currently driven.
  task automatic modelClock();
    if (mStopped) return;
    if (!mStarted) begin
      mStarted = 1; mFetching = 1;
    end else if (mFetching) begin
      if (imemAck) begin
        mIr = imemRdata;
        mPc = 16'((32'(mPc) + 1) % 65536);
        mValid = 1; mFetching = 0;
      end
    end else begin
      if (pcWrite || (pcWriteCond && aluZero)) mPc = selectPc(pcSrc, aluResult, jumpTarget, mPc);
      if (fetchNext) begin
        mValid = 0;
        if (halt) mStopped = 1; else mFetching = 1;
      end
    end
  endtask

  task automatic compareAll();
    check("imem_req",  imemReq,   mFetching && !mStopped);
    check("imem_addr", imemAddr,  mPc);
    check("pc_out",    pcOut,     mPc);
    check("ir_out",    irOut,     mIr);
    check("ir_valid",  irValid,   mValid);
    check("halted",    haltedOut, mStopped);
  endtask

  task automatic step();
    @(posedge clk);
    modelClock();
    @(negedge clk);
    compareAll();
  endtask

  task automatic doReset();
    rst_n = 0;
    modelReset();
    #1 compareAll();
    @(negedge clk);
    rst_n = 1;
  endtask

  int stopCycles;

  initial begin
    rst_n = 0;
    idleInputs();
    modelReset();
    #12;
    compareAll();
    check("wrap_reset_pc", wrapPc, 16'hFFFF);
    @(negedge clk);
    rst_n = 1;

    // First fetch, ack in the first REQ cycle.
    step();
    check("first_addr", imemAddr, 16'h0000);
    check("wrap_first_addr", wrapAddr, 16'hFFFF);
    imemAck = 1; imemRdata = 32'h8C220004;
    step();
    imemAck = 0;
    check("first_ir", irOut, 32'h8C220004);
    check("first_valid", irValid, 1'b1);
    check("first_pc", pcOut, 16'h0001);
    check("wrap_pc", wrapPc, 16'h0000);

    // Delayed ack: request held with a stable address.
    fetchNext = 1;
    step();
    fetchNext = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("delay_req", imemReq, 1'b1);
      check("delay_addr", imemAddr, 16'h0001);
    end
    imemAck = 1; imemRdata = 32'h00A5_5A00;
    step();
    imemAck = 0;
    check("delay_pc", pcOut, 16'h0002);

    // Conditional branch: not taken, then taken.
    pcWriteCond = 1; aluZero = 0; pcSrc = 2'b00; aluResult = 32'h0000_0040;
    step();
    check("br_not_taken", pcOut, 16'h0002);
    aluZero = 1;
    step();
    check("br_taken", pcOut, 16'h0040);
    idleInputs();
    fetchNext = 1;
    step();
    fetchNext = 0;
    check("br_fetch_addr", imemAddr, 16'h0040);
    imemAck = 1; imemRdata = 32'h1111_2222;
    step();
    imemAck = 0;

    // Jump together with fetch_next.
    pcWrite = 1; pcSrc = 2'b01; jumpTarget = 16'h1234; fetchNext = 1;
    step();
    idleInputs();
    check("jump_addr", imemAddr, 16'h1234);
    check("jump_valid_drop", irValid, 1'b0);
    imemAck = 1; imemRdata = 32'hDEAD_BEEF;
    step();
    imemAck = 0;

    // Halt, then redirect pulses and acks must have no effect.
    fetchNext = 1; halt = 1;
    step();
    idleInputs();
    check("halted_set", haltedOut, 1'b1);
    for (int i = 0; i < 12; i++) begin
      pcWrite = i[0]; pcSrc = 2'($urandom); jumpTarget = 16'($urandom);
      aluResult = $urandom; imemAck = 1;
      step();
      check("halt_no_req", imemReq, 1'b0);
    end
    idleInputs();

    // Reset asserted mid-REQ.
    doReset();
    step();
    imemAck = 1; imemRdata = 32'h0BAD_F00D;
    step();
    imemAck = 0; fetchNext = 1;
    step();
    fetchNext = 0;
    step();
    check("pre_reset_req", imemReq, 1'b1);
    #2 rst_n = 0;
    #1;
    check("reset_req_drop", imemReq, 1'b0);
    check("reset_pc", pcOut, 16'h0000);
    modelReset();
    @(negedge clk);
    compareAll();
    rst_n = 1;

    // Randomized traffic.
    stopCycles = 0;
    for (int n = 0; n < 1500; n++) begin
      imemAck     = ($urandom_range(0, 2) == 0);
      imemRdata   = $urandom;
      pcWrite     = ($urandom_range(0, 7) == 0);
      pcWriteCond = ($urandom_range(0, 5) == 0);
      aluZero     = 1'($urandom);
      pcSrc       = 2'($urandom);
      aluResult   = $urandom;
      jumpTarget  = 16'($urandom);
      fetchNext   = ($urandom_range(0, 2) == 0);
      halt        = ($urandom_range(0, 39) == 0);
      step();
      if (mStopped) stopCycles++;
      if (stopCycles >= 5) begin
        stopCycles = 0;
        idleInputs();
        doReset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the 16-bit program counter and the instruction register for the multicycle datapath.
- Issues a req/ack fetch to instruction memory, latches the returned word and advances PC by one word.
- Holds the instruction until control releases it, and applies PC redirects (jump, branch) from control.
- pc_out is the PC operand consumed by the ALU source-A select stage, zero-extended there to DATA_WIDTH.

Parameters:
- DATA_WIDTH, 32, instruction/ALU data width.
- PC_WIDTH, 16, PC and instruction-address width; word-addressed.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  PC_WIDTH  fetch address; always equals pc_out.
- imem_ack  input  1  memory returns data this cycle.
- imem_rdata  input  DATA_WIDTH  fetched instruction word.
- ir_out  output  DATA_WIDTH  instruction register.
- ir_valid  output  1  ir_out holds an unconsumed instruction.
- fetch_next  input  1  control pulse: release IR and fetch the next instruction.
- halt  input  1  sampled with fetch_next; stops fetching.
- pc_write  input  1  unconditional PC load.
- pc_write_cond  input  1  PC load if alu_zero.
- alu_zero  input  1  ALU zero flag.
- pc_src  input  2  next-PC select: 00 alu_result[15:0]; 01 jump_target; 10 pc+1; 11 hold current PC.
- alu_result  input  DATA_WIDTH  ALU output (branch target / computed address).
- jump_target  input  PC_WIDTH  jump field from decode.
- pc_out  output  PC_WIDTH  current PC register.
- halted  output  1  unit is in HALTED.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC, ir_out = 0, ir_valid = 0, imem_req = 0, halted = 0, state = IDLE.
  - A reset asserted mid-fetch aborts the fetch immediately; no IR or PC update occurs.
- FSM states: IDLE, REQ, HOLD, HALTED. All outputs are registered or decoded from the state register.
- IDLE:
  - One cycle after reset release, unconditionally go to REQ.
- REQ:
  - imem_req = 1, imem_addr = pc.
  - On a cycle with imem_ack = 1: ir_out <= imem_rdata, pc <= pc+1 (0xFFFF wraps to 0x0000), ir_valid <= 1, go to HOLD.
  - No ack: remain in REQ with address stable; there is no timeout.
  - Minimum latency: req asserted in cycle N, ack in N → ir_valid = 1 in N+1.
- HOLD:
  - imem_req = 0; ir_out is stable.
  - Redirect rule: pc updates when pc_write = 1, or when pc_write_cond = 1 and alu_zero = 1. New value is selected by pc_src; pc_src = 11 leaves pc unchanged.
  - Multiple redirects per HOLD are allowed; the last one wins.
  - On fetch_next = 1 with halt = 0: ir_valid <= 0, go to REQ.
  - On fetch_next = 1 with halt = 1: ir_valid <= 0, halted <= 1, go to HALTED.
  - Redirect and fetch_next in the same cycle: pc takes the redirect value, and the following REQ fetches from that new value.
- Redirects in IDLE, REQ or HALTED are ignored; pc changes only on fetch ack or in HOLD.
- imem_ack outside REQ is ignored.
- HALTED: no requests are issued; only reset exits this state.
- Width rules:
  - alu_result is truncated to its low PC_WIDTH bits.
  - pc+1 is computed modulo 2^PC_WIDTH.
  - No sign extension anywhere.

Decomposition:
- Shared package (cpu_pkg) holds:
  - fetch state encoding.
  - pc_src codes: PCSRC_ALU, PCSRC_JUMP, PCSRC_INC, PCSRC_HOLD.
  - PC_WIDTH and DATA_WIDTH constants.
- One natural sub-module, pc_next_sel: combinational next-PC select (pc_src, alu_result, jump_target, pc), instantiated once.
- FSM, PC register and IR stay in pc_fetch_unit.

Test Plan:
- Reset then ack in the first REQ cycle with rdata 0x8C220004 → imem_addr 0x0000, ir_out 0x8C220004, ir_valid = 1 and pc_out 0x0001 one cycle after ack.
- Delayed ack: hold imem_ack low for 3 cycles in REQ → imem_req stays high with addr stable at 0x0001; no pc change until ack.
- Conditional branch: in HOLD, pc_write_cond = 1, alu_zero = 0, pc_src = 00, alu_result 0x00000040 → pc unchanged. Repeat with alu_zero = 1 → pc = 0x0040, and the next REQ address is 0x0040.
- Jump and fetch_next in the same cycle with jump_target 0x1234, pc_write = 1 → next imem_addr = 0x1234; ir_valid drops one cycle later.
- Wrap: RESET_PC = 0xFFFF, complete one fetch → pc_out = 0x0000.
- Halt, then reset mid-operation:
  - fetch_next with halt = 1 → halted = 1; imem_req stays 0 for 10+ cycles despite pc_write pulses.
  - Assert rst_n low while in REQ → imem_req = 0 immediately; pc = RESET_PC.
